mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one sequential multiply unit (WIDTH x WIDTH -> 2*WIDTH, start/done handshake) among NUM_REQ requesters.
- Selects requesters round-robin, latches their operands, pulses the unit's start and waits for done.
- Returns the product tagged with the requester ID over a valid/ready response channel.
- Includes a watchdog timeout so a hung multiplier cannot deadlock the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); ID_W = clog2(NUM_REQ) is derived, not overridable.
- WIDTH, 32, operand width; product width is 2*WIDTH.
- TIMEOUT, 64, max cycles in WAIT before abort (>= 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- mul_start  out  1  one-cycle start pulse to multiply unit
- mul_a  out  WIDTH  operand A to unit, stable from ISSUE until leaving WAIT
- mul_b  out  WIDTH  operand B to unit, same stability
- mul_done  in  1  unit completion pulse
- mul_product  in  2*WIDTH  unit result, valid when mul_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester served
- rsp_product  out  2*WIDTH  product (0 on timeout)
- rsp_err  out  1  1 = timeout abort
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is clk/reset as decided: asynchronous, active-high.
  - Reset values: state IDLE; mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy all 0.
  - req_ready is 0 while reset is asserted.
  - Priority pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Timeout counter = 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i], searching from last_grant+1 modulo NUM_REQ.
  - req_ready = onehot(g), combinational, only when any req_valid is high; otherwise 0.
  - On handshake: latch req_a[g] and req_b[g] into mul_a/mul_b, latch g into the id register, go to ISSUE.
  - A requester may drop req_valid before ready; nothing is consumed.
- ISSUE: mul_start=1 for exactly this cycle; counter cleared; go to WAIT. mul_done sampled here is ignored.
- WAIT:
  - If mul_done=1: rsp_product <= mul_product, rsp_err <= 0, go to RESP.
  - Else counter++. When counter reaches TIMEOUT-1 without done: rsp_product <= 0, rsp_err <= 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - rsp_valid=1; rsp_id, rsp_product and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that cycle: last_grant <= id, go to IDLE.
  - No req_ready is asserted while in RESP (single outstanding operation).
  - mul_done is ignored in IDLE and RESP, including a late done after a timeout.
- Latency, unit done N cycles after start (N >= 1):
  - Request accepted at cycle 0, mul_start at cycle 1, done at cycle 1+N, rsp_valid at cycle 2+N.
  - Next grant is possible the cycle after the response handshake.
- Arithmetic: the block passes products through unmodified; no truncation or sign handling (unsigned).
- Reset mid-operation: everything returns to reset values immediately; in-flight request and response are discarded; next grant starts from requester 0.
- Fairness: with all requesters continuously valid, each is served once per NUM_REQ responses.

Test Plan:
1. req_valid=0001, a=3, b=5; model asserts done 3 cycles after start with 15 -> mul_start high exactly 1 cycle; rsp_valid 5 cycles after accept with id=0, product=15, err=0.
2. req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; req_ready never multi-hot.
3. a=b=0xFFFFFFFF on requester 2 -> rsp_product=0xFFFFFFFE00000001, id=2.
4. Model never asserts done -> rsp after TIMEOUT cycles in WAIT with err=1, product=0; a late done is ignored; next request completes normally.
5. rsp_ready low for 10 cycles with req_valid=1111 -> response fields stable, req_ready=0 throughout, busy=1.
6. Assert reset during WAIT -> outputs at reset values next edge; stale done ignored; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_share_arbiter
//  Brief    : Round-robin front end that shares one sequential WIDTHxWIDTH
//             multiply unit among NUM_REQ requesters. It latches the winning
//             operands, pulses start, waits for done (guarded by a watchdog),
//             and returns the product tagged with the requester ID over a
//             valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_product,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic                       rsp_err,
  output logic                       busy
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int                CNT_W       = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(TIMEOUT - 1);
  // Pointer starts at the last requester so requester 0 wins first.
  localparam logic [ID_W-1:0]   c_LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_last_grant;
  logic [ID_W-1:0]      r_id;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_mul_start;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic                 r_rsp_valid;
  logic [2*WIDTH-1:0]   r_rsp_product;
  logic                 r_rsp_err;
  logic                 r_busy;

  logic                 w_found;
  logic [ID_W-1:0]      w_grant;
  logic [ID_W-1:0]      w_cand;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic [NUM_REQ-1:0]   w_req_ready;

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = ID_W'((int'(r_last_grant) + off) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept, only in IDLE and never while reset is held.
  always_comb begin
    w_req_ready = '0;
    if (!reset && (r_state == ST_IDLE) && w_found) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  // Main sequencer: accept, issue start, wait with watchdog, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= c_LAST_INIT;
      r_id          <= '0;
      r_cnt         <= '0;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Any valid requester means a handshake this cycle.
          if (w_found) begin
            r_mul_a     <= w_sel_a;
            r_mul_b     <= w_sel_b;
            r_id        <= w_grant;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Start was high for this cycle only; done seen here is ignored.
          r_mul_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (mul_done) begin
            r_rsp_product <= mul_product;
            r_rsp_err     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          // Fields hold until accepted; the served ID becomes the new pointer.
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_id;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_product = r_rsp_product;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_arbiter
//  Brief    : Self-checking bench for mult_share_arbiter with a behavioural
//             multiply-unit responder and a round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 12;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_done;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     rsp_err;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state and multiply-unit behaviour knobs
  int          ref_last;
  int          mdl_delay;
  bit          mdl_hang;
  bit          inj_done;
  int          cd;
  logic [63:0] mprod;
  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // Multiply unit: done mdl_delay cycles after the start cycle, or never.
  always @(posedge clk) begin
    if (reset) begin
      cd = 0;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      if (mul_start) begin
        cd    = mdl_hang ? 0 : mdl_delay;
        mprod = {32'b0, mul_a} * {32'b0, mul_b};
      end else if (cd > 0) begin
        cd--;
      end
      mul_done    <= (cd == 1) || inj_done;
      mul_product <= (cd == 1) ? mprod : 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  endtask

  // One full operation from IDLE through the response handshake.
  task automatic run_op(input logic [NUM_REQ-1:0] vmask, input int delay, input bit hang,
                        input int stall, input bit late, output int got_id);
    int          g;
    int          c;
    int          starts;
    int          exp_lat;
    bit          exp_e;
    bit          arrived;
    logic [63:0] exp_p;
    g       = pick(ref_last, vmask);
    exp_e   = hang || (delay > TIMEOUT);
    exp_p   = exp_e ? 64'd0 : {32'b0, op_a[g]} * {32'b0, op_b[g]};
    exp_lat = 2 + (exp_e ? TIMEOUT : delay);
    pack_ops();
    req_valid = vmask;
    rsp_ready = (stall == 0);
    mdl_delay = delay;
    mdl_hang  = hang;
    #1;
    check("idle_ready_onehot", req_ready, 64'(1) << g);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    tick();
    check("issue_start", mul_start, 1);
    check("issue_mul_a", mul_a, op_a[g]);
    check("issue_mul_b", mul_b, op_b[g]);
    check("issue_busy", busy, 1);
    check("issue_ready", req_ready, 0);
    starts  = 1;
    c       = 1;
    arrived = 0;
    while (!arrived && c < exp_lat + 4) begin
      tick();
      c++;
      if (mul_start === 1'b1) starts++;
      check("wait_ready", req_ready, 0);
      if (rsp_valid === 1'b1) arrived = 1;
    end
    check("rsp_arrived", arrived, 1);
    check("rsp_latency", c, exp_lat);
    check("start_pulses", starts, 1);
    check("rsp_id", rsp_id, g);
    check("rsp_product", rsp_product, exp_p);
    check("rsp_err", rsp_err, exp_e);
    got_id = int'(rsp_id);
    if (late) inj_done = 1;
    for (int s = 0; s < stall; s++) begin
      tick();
      inj_done = 0;
      check("stall_valid", rsp_valid, 1);
      check("stall_id", rsp_id, g);
      check("stall_product", rsp_product, exp_p);
      check("stall_err", rsp_err, exp_e);
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
    end
    rsp_ready = 1;
    tick();
    inj_done = 0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    ref_last = g;
  endtask

  initial begin
    int id;
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    reset     = 1;
    req_valid = 4'hF;
    rsp_ready = 0;
    inj_done  = 0;
    mdl_delay = 1;
    mdl_hang  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 0;
      op_b[i] = 0;
    end
    pack_ops();
    tick();
    // Reset values
    check("rst_ready", req_ready, 0);
    check("rst_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    tick();
    reset     = 0;
    req_valid = 0;
    ref_last  = NUM_REQ - 1;
    #1;
    check("idle_no_valid_ready", req_ready, 0);
    tick();
    check("idle_no_valid_busy", busy, 0);

    // Fairness with all requesters valid
    for (int k = 0; k < 6; k++) begin
      op_a[k % NUM_REQ] = $urandom;
      op_b[k % NUM_REQ] = $urandom;
      run_op(4'hF, $urandom_range(1, 4), 0, 0, 0, id);
      check("rr_sequence", id, exp_seq[k]);
    end

    // Single requester, 3 * 5 with done 3 cycles after start
    op_a[0] = 32'd3;
    op_b[0] = 32'd5;
    run_op(4'b0001, 3, 0, 0, 0, id);

    // Largest operands on requester 2
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'hFFFF_FFFF;
    run_op(4'b0100, 2, 0, 0, 0, id);
    check("max_product_direct", dut.rsp_product, 64'hFFFF_FFFE_0000_0001);

    // Done arriving exactly at watchdog expiry wins; one cycle later loses
    op_a[1] = 32'd7;
    op_b[1] = 32'd9;
    run_op(4'b0010, TIMEOUT, 0, 0, 0, id);
    run_op(4'b0010, TIMEOUT + 1, 0, 0, 0, id);

    // Hung unit with a late done during RESP, then a late done in IDLE
    run_op(4'b0010, 1, 1, 2, 1, id);
    req_valid = 0;
    inj_done  = 1;
    tick();
    inj_done  = 0;
    tick();
    tick();
    check("late_done_idle_busy", busy, 0);
    check("late_done_idle_valid", rsp_valid, 0);
    run_op(4'b0010, 2, 0, 0, 0, id);

    // Long response stall with everyone requesting
    run_op(4'hF, 2, 0, 10, 0, id);

    // Reset during WAIT
    pack_ops();
    req_valid = 4'hF;
    rsp_ready = 1;
    mdl_hang  = 1;
    tick();
    tick();
    tick();
    check("pre_reset_busy", busy, 1);
    reset = 1;
    #1;
    check("midrst_ready", req_ready, 0);
    check("midrst_start", mul_start, 0);
    check("midrst_mul_a", mul_a, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_err", rsp_err, 0);
    check("midrst_busy", busy, 0);
    tick();
    tick();
    reset     = 0;
    req_valid = 0;
    mdl_hang  = 0;
    inj_done  = 1;
    tick();
    inj_done  = 0;
    tick();
    tick();
    check("stale_done_busy", busy, 0);
    check("stale_done_valid", rsp_valid, 0);
    ref_last = NUM_REQ - 1;
    run_op(4'hF, 2, 0, 0, 0, id);
    check("first_after_reset", id, 0);

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        op_a[i] = $urandom;
        op_b[i] = $urandom;
      end
      run_op(4'($urandom_range(1, 15)), $urandom_range(1, TIMEOUT + 3),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
